// File: rtl/fft_unbuffer.sv
// fft_unbuffer
// Turns parallel FFT result frames into a serial stream of points. Two frame
// slots are used in ping-pong order so a new frame can be captured while the
// previous one is still being streamed out.
//
// Parameters:
//   N - FFT points per frame (index_o is 4 bits wide, so N <= 16)
//   W - bits per point, {real[15:0], imag[15:0]} by default
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous, active-low reset
//   data_valid_i - one-cycle pulse marking y as a valid frame
//   y            - parallel frame, point k at bits [W*k+W-1 : W*k]
//   in_ready_o   - a frame slot is free
//   data_o       - current serial point (0 while idle)
//   data_valid_o - data_o is valid
//   ready_i      - downstream accepts data_o this cycle
//   index_o      - point index of data_o
//   last_o       - data_o is the final point of its frame
//   overflow_o   - sticky flag, a frame arrived with both slots full
//   frame_cnt_o  - number of completely sent frames, wraps at 256
module fft_unbuffer #(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           data_valid_i,
    input  logic [N*W-1:0] y,
    output logic           in_ready_o,
    output logic [W-1:0]   data_o,
    output logic           data_valid_o,
    input  logic           ready_i,
    output logic [3:0]     index_o,
    output logic           last_o,
    output logic           overflow_o,
    output logic [7:0]     frame_cnt_o
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    state_t       state_q, state_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic [3:0]   idx_q, idx_d;
    logic         overflow_q, overflow_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;

    logic [W-1:0] slot_q [2][N];

    logic         in_ready;
    logic         capture;
    logic         xfer;
    logic         last_xfer;

    // Frame acceptance looks only at the registered count, so a frame that
    // arrives while both slots are full is dropped even if the slot being
    // streamed frees up on that same edge.
    always_comb begin
        in_ready  = (count_q != 2'd2);
        capture   = data_valid_i && in_ready;
        xfer      = (state_q == STREAM) && ready_i;
        last_xfer = xfer && (idx_q == LAST_IDX);
    end

    // Next-state logic. The count only changes when exactly one of capture
    // and final transfer happens; doing both keeps it steady, which is what
    // lets the next frame follow with no bubble.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        idx_d       = idx_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;

        if (capture) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (data_valid_i && !in_ready) begin
            overflow_d = 1'b1;
        end

        if (xfer) begin
            if (last_xfer) begin
                idx_d       = 4'd0;
                rd_ptr_d    = ~rd_ptr_q;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end

        case ({capture, last_xfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer && (count_d == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            idx_q       <= 4'd0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Slot storage has no reset; contents are only observed while streaming.
    // A capture can only target the slot not being read, because capture
    // while streaming requires count == 1, which means wr_ptr != rd_ptr.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                slot_q[wr_ptr_q][k] <= y[k*W +: W];
            end
        end
    end

    // Outputs come straight from registers, so they stay stable while the
    // downstream stalls.
    always_comb begin
        in_ready_o   = in_ready;
        data_valid_o = (state_q == STREAM);
        data_o       = (state_q == STREAM) ? slot_q[rd_ptr_q][idx_q] : '0;
        index_o      = idx_q;
        last_o       = (state_q == STREAM) && (idx_q == LAST_IDX);
        overflow_o   = overflow_q;
        frame_cnt_o  = frame_cnt_q;
    end

endmodule

// File: tb/tb_fft_unbuffer.sv
// Testbench for fft_unbuffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the frame stream.
module tb_fft_unbuffer;

   localparam int N = 16;
   localparam int W = 32;

   logic           clk;
   logic           rst;
   logic           data_valid_i;
   logic [N*W-1:0] y;
   logic           in_ready_o;
   logic [W-1:0]   data_o;
   logic           data_valid_o;
   logic           ready_i;
   logic [3:0]     index_o;
   logic           last_o;
   logic           overflow_o;
   logic [7:0]     frame_cnt_o;

   fft_unbuffer #(.N(N), .W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_valid_i (data_valid_i),
      .y            (y),
      .in_ready_o   (in_ready_o),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .ready_i      (ready_i),
      .index_o      (index_o),
      .last_o       (last_o),
      .overflow_o   (overflow_o),
      .frame_cnt_o  (frame_cnt_o)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   bit checkEn = 1'b0;

   // Model: queue of held frames (front is being streamed), the point index
   // within the front frame, the sticky overflow bit and the sent-frame count.
   logic [N*W-1:0] modelQ[$];
   int             modelIdx = 0;
   bit             modelOvf = 1'b0;
   int             modelFc = 0;

   function automatic logic [W-1:0] expData();
      logic [N*W-1:0] f;
      if (modelQ.size() == 0) return '0;
      f = modelQ[0];
      return f[modelIdx*W +: W];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      else
         passes++;
   endtask

   // Drive one cycle of inputs, let the edge happen, then advance the model
   // using the same inputs. Returns 1 time unit after the edge.
   task automatic applyStimulus(input bit dv, input logic [N*W-1:0] yv, input bit rdy, input bit rstn);
      bit xfer;
      bit cap;
      data_valid_i = dv;
      y            = yv;
      ready_i      = rdy;
      rst          = rstn;
      @(posedge clk);
      if (!rstn) begin
         modelQ.delete();
         modelIdx = 0;
         modelOvf = 1'b0;
         modelFc  = 0;
      end else begin
         xfer = (modelQ.size() > 0) && rdy;
         cap  = dv && (modelQ.size() < 2);
         if (xfer) begin
            modelIdx++;
            if (modelIdx == N) begin
               void'(modelQ.pop_front());
               modelIdx = 0;
               modelFc  = (modelFc + 1) % 256;
            end
         end
         if (cap) modelQ.push_back(yv);
         else if (dv) modelOvf = 1'b1;
      end
      #1;
   endtask

   // Per-cycle comparison of every output against the model, away from the edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("data_valid_o", 32'(data_valid_o), 32'(modelQ.size() > 0));
         checkOutput("data_o", data_o, expData());
         checkOutput("index_o", 32'(index_o), 32'(modelIdx));
         checkOutput("last_o", 32'(last_o), 32'((modelQ.size() > 0) && (modelIdx == N - 1)));
         checkOutput("in_ready_o", 32'(in_ready_o), 32'(modelQ.size() < 2));
         checkOutput("overflow_o", 32'(overflow_o), 32'(modelOvf));
         checkOutput("frame_cnt_o", 32'(frame_cnt_o), 32'(modelFc));
      end
   end

   function automatic logic [N*W-1:0] randFrame();
      logic [N*W-1:0] f;
      for (int k = 0; k < N; k++) f[k*W +: W] = $urandom;
      return f;
   endfunction

   function automatic logic [N*W-1:0] rampFrame();
      logic [N*W-1:0] f;
      logic [15:0]    kk;
      for (int k = 0; k < N; k++) begin
         kk = k[15:0];
         f[k*W +: W] = {kk, ~kk};
      end
      return f;
   endfunction

   // Stimulus sequence: directed scenarios first, then random traffic, then
   // the frame-counter wrap.
   initial begin
      logic [N*W-1:0] fa, fb, fc;
      int captured;
      bit done;

      rst = 1'b0;
      data_valid_i = 1'b0;
      y = '0;
      ready_i = 1'b0;

      // Reset state
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkEn = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("reset in_ready_o", 32'(in_ready_o), 32'd1);
      checkOutput("reset data_valid_o", 32'(data_valid_o), 32'd0);
      checkOutput("reset data_o", data_o, 32'd0);

      // Ramp frame at full rate
      applyStimulus(1'b1, rampFrame(), 1'b1, 1'b1);
      checkOutput("ramp first valid", 32'(data_valid_o), 32'd1);
      checkOutput("ramp first index", 32'(index_o), 32'd0);
      checkOutput("ramp first data", data_o, 32'h0000FFFF);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("ramp last_o", 32'(last_o), 32'd1);
      checkOutput("ramp last data", data_o, 32'h000FFFF0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("ramp done valid", 32'(data_valid_o), 32'd0);
      checkOutput("ramp frame_cnt", 32'(frame_cnt_o), 32'd1);

      // Back-pressure with ready toggling
      applyStimulus(1'b1, randFrame(), 1'b0, 1'b1);
      for (int i = 0; i < 32; i++) applyStimulus(1'b0, '0, (i % 2) == 0, 1'b1);
      checkOutput("bp done valid", 32'(data_valid_o), 32'd0);
      checkOutput("bp frame_cnt", 32'(frame_cnt_o), 32'd2);

      // Second frame arrives mid-stream; frames must run back to back
      fa = randFrame();
      fb = randFrame();
      applyStimulus(1'b1, fa, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
      applyStimulus(1'b1, fb, 1'b1, 1'b1);
      for (int i = 0; i < 26; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("b2b still valid", 32'(data_valid_o), 32'd1);
      checkOutput("b2b index 15", 32'(index_o), 32'd15);
      checkOutput("b2b data", data_o, fb[15*W +: W]);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("b2b done valid", 32'(data_valid_o), 32'd0);
      checkOutput("b2b frame_cnt", 32'(frame_cnt_o), 32'd4);
      checkOutput("b2b overflow", 32'(overflow_o), 32'd0);

      // Three frames in a row while stalled: third is dropped
      fa = randFrame();
      fb = randFrame();
      fc = randFrame();
      applyStimulus(1'b1, fa, 1'b0, 1'b1);
      applyStimulus(1'b1, fb, 1'b0, 1'b1);
      applyStimulus(1'b1, fc, 1'b0, 1'b1);
      checkOutput("ovf overflow", 32'(overflow_o), 32'd1);
      checkOutput("ovf in_ready", 32'(in_ready_o), 32'd0);
      checkOutput("ovf data frame1", data_o, fa[W-1:0]);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("ovf data frame2", data_o, fb[W-1:0]);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("ovf done valid", 32'(data_valid_o), 32'd0);
      checkOutput("ovf frame_cnt", 32'(frame_cnt_o), 32'd6);

      // Reset in the middle of a frame
      applyStimulus(1'b1, randFrame(), 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("mid index 7", 32'(index_o), 32'd7);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("rst valid", 32'(data_valid_o), 32'd0);
      checkOutput("rst frame_cnt", 32'(frame_cnt_o), 32'd0);
      checkOutput("rst in_ready", 32'(in_ready_o), 32'd1);
      checkOutput("rst overflow", 32'(overflow_o), 32'd0);
      fa = randFrame();
      applyStimulus(1'b1, fa, 1'b1, 1'b1);
      checkOutput("restart index", 32'(index_o), 32'd0);
      checkOutput("restart data", data_o, fa[W-1:0]);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

      // Randomized traffic, stalls and occasional resets
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom % 5) == 0, randFrame(), ($urandom % 3) != 0, ($urandom % 97) != 0);

      // Frame counter wrap over 256 continuously streamed frames
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      captured = 0;
      done = 1'b0;
      for (int i = 0; i < 6000 && !done; i++) begin
         if (captured < 256 && modelQ.size() < 2) begin
            applyStimulus(1'b1, randFrame(), 1'b1, 1'b1);
            captured++;
         end else begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
         end
         if (captured == 256 && modelQ.size() == 0) done = 1'b1;
      end
      if (!done) begin
         checks++;
         $display("[TB] FAIL wrap timeout: got %0d frames captured, expected 256 drained", captured);
      end
      checkOutput("wrap frame_cnt", 32'(frame_cnt_o), 32'd0);
      checkOutput("wrap overflow", 32'(overflow_o), 32'd0);

      checkEn = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fft_unbuffer.md
FFT_UNBUFFER -- requirements
Module: fft_unbuffer

Interface
REQ-001 SHALL have parameter N, default 16, meaning FFT points per frame.
REQ-002 SHALL have parameter W, default 32, meaning bits per point ({real[15:0], imag[15:0]}).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset that is synchronous and active-low.
REQ-005 SHALL have port data_valid_i, input, 1 bit: a one-cycle pulse marking y as a valid FFT result frame.
REQ-006 SHALL have port y, input, N*W bits: the parallel frame; point k occupies bits [W*k+W-1 : W*k].
REQ-007 SHALL have port in_ready_o, output, 1 bit: high when a frame slot is free.
REQ-008 SHALL have port data_o, output, W bits: the current serial point.
REQ-009 SHALL have port data_valid_o, output, 1 bit: data_o is valid.
REQ-010 SHALL have port ready_i, input, 1 bit: downstream accepts data_o this cycle.
REQ-011 SHALL have port index_o, output, 4 bits: point index k of data_o.
REQ-012 SHALL have port last_o, output, 1 bit: high when index_o == N-1 and data_valid_o is high.
REQ-013 SHALL have port overflow_o, output, 1 bit: sticky flag set when a frame is dropped.
REQ-014 SHALL have port frame_cnt_o, output, 8 bits: count of completely sent frames, wrapping 255 -> 0.

Function
REQ-015 SHALL hold two N-point frame slots in ping-pong order, tracked by wr_ptr, rd_ptr (1 bit each) and count (0..2).
REQ-016 SHALL drive in_ready_o = (count < 2), computed from registered count only.
REQ-017 SHALL capture y into slot[wr_ptr] at an edge where data_valid_i is high and in_ready_o is high, then toggle wr_ptr.
REQ-018 SHALL NOT capture y when data_valid_i is high and count == 2, even if the final word of a frame transfers on that same edge.
REQ-019 SHALL, in the case of REQ-018, drop the frame and set overflow_o to 1; overflow_o clears only on reset.
REQ-020 SHALL implement FSM IDLE/STREAM transitions as follows:
- IDLE -> STREAM on capture.
- STREAM -> IDLE on the last transfer when count becomes 0.
- Otherwise remain in the current state.
REQ-021 SHALL drive data_valid_o = 1 exactly when the FSM is in STREAM.
REQ-022 SHALL drive data_o = slot[rd_ptr] point idx and index_o = idx.
REQ-023 SHALL, first-word latency: assert data_valid_o with index_o = 0 in the cycle immediately after the capturing edge when the block was idle.
REQ-024 SHALL define a transfer as data_valid_o && ready_i at a rising edge; on a transfer idx increments.
REQ-025 SHALL hold data_o, index_o and last_o stable while data_valid_o && !ready_i.
REQ-026 SHALL, on a transfer with idx == N-1:
- set idx to 0;
- toggle rd_ptr;
- decrement count;
- increment frame_cnt_o.
REQ-027 SHALL, on simultaneous capture and final transfer with count == 1, leave count at 1 and give back-to-back output: the next frame's index 0 appears in the very next cycle with no bubble.
REQ-028 SHALL never overwrite slot[rd_ptr] while it is being streamed.
REQ-029 SHALL sustain one point per cycle when ready_i is held high.

Reset
REQ-030 SHALL, at a rising edge where rst == 0, force the following, regardless of any frame in progress:
- FSM to IDLE;
- count, wr_ptr, rd_ptr and idx to 0;
- data_valid_o, last_o, overflow_o and index_o to 0;
- frame_cnt_o to 0;
- in_ready_o to 1.
REQ-031 SHALL discard any partially sent frame on reset; slot contents need no reset.
REQ-032 SHALL drive data_o to 0 during reset and while IDLE.

Verification
REQ-033 SHALL cover, with ready_i = 1, one frame where point k = {k, ~k} (16-bit fields) -> data_o sequence k = 0..15 on 16 consecutive cycles starting one cycle after capture, last_o high only at k = 15, then frame_cnt_o = 1.
REQ-034 SHALL cover back-pressure, ready_i toggling 1,0,1,0 -> each point held stable while ready_i = 0, all 16 points delivered in order, 32 cycles total.
REQ-035 SHALL cover a second frame pulsed 5 cycles after the first with ready_i = 1 -> frames stream back to back with no gap, frame_cnt_o = 2, overflow_o = 0.
REQ-036 SHALL cover three frames pulsed on consecutive cycles with ready_i = 0 -> first two held, third dropped, overflow_o = 1; after ready_i = 1, exactly 32 points are output, from frames 1 and 2.
REQ-037 SHALL cover rst = 0 for one edge at index 7 of a frame -> next cycle data_valid_o = 0, frame_cnt_o = 0, in_ready_o = 1; a new frame then starts at index 0.
REQ-038 SHALL cover 256 frames streamed continuously -> frame_cnt_o wraps to 0.
